// File: rtl/aes_ctr_axil_regs_if.sv
// AXI4-Lite bundle between the interconnect master and the AES-CTR register block.
interface aes_ctr_axil_regs_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/aes_ctr_axil_regs.sv
// AXI4-Lite register file fronting the AES-CTR core (base 0x44C0_0000, only the offset is decoded).
// Optional macro AES_CTR_AUTO_INC_EN: ST advances by one on every accepted core_done.
module aes_ctr_axil_regs #(
  parameter int ADDR_W  = 8,
  parameter int NO_KEYS = 3
) (
  input  logic                aclk,
  input  logic                aresetn,
  aes_ctr_axil_regs_if.slave  s_axi,
  output logic                core_start,
  output logic [127:0]        core_pt,
  output logic [127:0]        core_st,
  output logic [191:0]        core_key,
  input  logic                core_done,
  input  logic [127:0]        core_ct
);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] W_START = 32'd0;
  localparam logic [31:0] W_PT    = 32'd1;
  localparam logic [31:0] W_KEY0  = 32'd5;
  localparam logic [31:0] W_DONE  = 32'd11;
  localparam logic [31:0] W_CT    = 32'd12;
  localparam logic [31:0] W_ST    = 32'd16;
  localparam logic [31:0] W_KEY1  = 32'd20;
  localparam logic [31:0] W_KEY2  = 32'd26;
  localparam logic [31:0] W_SEL   = 32'd32;

  logic [31:0] pt  [4];
  logic [31:0] st  [4];
  logic [31:0] ct  [4];
  logic [31:0] key [NO_KEYS][6];
  logic [1:0]  key_sel;
  logic        start_bit, done_bit, busy;

  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  // The key slots are not contiguous in the map, so each has its own base word.
  function automatic logic [31:0] key_base(input int k);
    case (k)
      0:       return W_KEY0;
      1:       return W_KEY1;
      default: return W_KEY2;
    endcase
  endfunction

  logic aw_hs, w_hs, ar_hs, commit;
  logic aw_held_n, w_held_n, bvalid_n, rvalid_n;

  assign aw_hs     = s_axi.awvalid & s_axi.awready;
  assign w_hs      = s_axi.wvalid & s_axi.wready;
  assign ar_hs     = s_axi.arvalid & s_axi.arready;
  assign commit    = aw_held & w_held & ~s_axi.bvalid;
  assign aw_held_n = (aw_held | aw_hs) & ~commit;
  assign w_held_n  = (w_held | w_hs) & ~commit;
  assign bvalid_n  = commit | (s_axi.bvalid & ~s_axi.bready);
  assign rvalid_n  = ar_hs | (s_axi.rvalid & ~s_axi.rready);

  logic [31:0] wr_word, rd_word, sel_merged;
  logic        start_new, wr_err;

  assign wr_word    = 32'(aw_addr_q) >> 2;
  assign rd_word    = 32'(s_axi.araddr) >> 2;
  assign sel_merged = merge({30'b0, key_sel}, wdata_q, wstrb_q);
  assign start_new  = wstrb_q[0] ? wdata_q[0] : start_bit;

  // START is always accepted; every other writable field is locked while the core runs.
  always_comb begin
    wr_err = 1'b0;
    if (wr_word == W_START)                       wr_err = 1'b0;
    else if (wr_word >= W_DONE && wr_word < W_ST) wr_err = 1'b1;
    else if (wr_word > W_SEL)                     wr_err = 1'b1;
    else if (busy)                                wr_err = 1'b1;
    else if (wr_word == W_SEL)                    wr_err = (sel_merged > 32'd2);
  end

  logic [31:0] rd_data;
  logic        rd_hit;

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (rd_word == W_START) begin rd_data = {31'b0, start_bit}; rd_hit = 1'b1; end
    if (rd_word == W_DONE)  begin rd_data = {31'b0, done_bit};  rd_hit = 1'b1; end
    if (rd_word == W_SEL)   begin rd_data = {30'b0, key_sel};   rd_hit = 1'b1; end
    for (int i = 0; i < 4; i++) begin
      if (rd_word == W_PT + 32'(i)) begin rd_data = pt[i]; rd_hit = 1'b1; end
      if (rd_word == W_CT + 32'(i)) begin rd_data = ct[i]; rd_hit = 1'b1; end
      if (rd_word == W_ST + 32'(i)) begin rd_data = st[i]; rd_hit = 1'b1; end
    end
    for (int k = 0; k < NO_KEYS; k++)
      for (int j = 0; j < 6; j++)
        if (rd_word == key_base(k) + 32'(j)) begin rd_data = key[k][j]; rd_hit = 1'b1; end
  end

  logic [191:0] core_key_n;

  always_comb begin
    core_key_n = '0;
    for (int k = 0; k < NO_KEYS; k++)
      for (int j = 0; j < 6; j++)
        if (key_sel == 2'(k)) core_key_n[32*j +: 32] = key[k][j];
  end

  assign core_pt = {pt[3], pt[2], pt[1], pt[0]};
  assign core_st = {st[3], st[2], st[1], st[0]};

  logic [127:0] st_done;
`ifdef AES_CTR_AUTO_INC_EN
  assign st_done = core_st + 128'd1;
`else
  assign st_done = core_st;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= RESP_OKAY;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
      for (int i = 0; i < 4; i++) begin
        pt[i] <= '0;
        st[i] <= '0;
        ct[i] <= '0;
      end
      for (int k = 0; k < NO_KEYS; k++)
        for (int j = 0; j < 6; j++) key[k][j] <= '0;
      key_sel    <= '0;
      start_bit  <= 1'b0;
      done_bit   <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      core_key   <= '0;
    end else begin
      core_start    <= 1'b0;
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      s_axi.awready <= ~aw_held_n & ~bvalid_n;
      s_axi.wready  <= ~w_held_n & ~bvalid_n;
      s_axi.bvalid  <= bvalid_n;
      s_axi.arready <= ~rvalid_n;
      s_axi.rvalid  <= rvalid_n;
      core_key      <= core_key_n;
      if (aw_hs) aw_addr_q <= s_axi.awaddr;
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (ar_hs) begin
        s_axi.rdata <= rd_data;
        s_axi.rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
      if (core_done && busy) begin
        for (int i = 0; i < 4; i++) begin
          ct[i] <= core_ct[32*i +: 32];
          st[i] <= st_done[32*i +: 32];
        end
        done_bit <= 1'b1;
        busy     <= 1'b0;
      end
      if (commit) begin
        s_axi.bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (!wr_err) begin
          if (wr_word == W_START) begin
            start_bit <= start_new;
            if (!start_bit && start_new && !busy) begin
              core_start <= 1'b1;
              busy       <= 1'b1;
              done_bit   <= 1'b0;
            end
          end
          if (wr_word == W_SEL) key_sel <= sel_merged[1:0];
          for (int i = 0; i < 4; i++) begin
            if (wr_word == W_PT + 32'(i)) pt[i] <= merge(pt[i], wdata_q, wstrb_q);
            if (wr_word == W_ST + 32'(i)) st[i] <= merge(st[i], wdata_q, wstrb_q);
          end
          for (int k = 0; k < NO_KEYS; k++)
            for (int j = 0; j < 6; j++)
              if (wr_word == key_base(k) + 32'(j)) key[k][j] <= merge(key[k][j], wdata_q, wstrb_q);
        end
      end
    end
  end
endmodule
